uart_tx_fifo_ctrl: RTL

Parametrised UART transmitter with an input byte FIFO, runtime baud divisor, selectable parity and 1/2 stop bits. Sits between a valid/ready word producer and the serial TX pin. It supersedes the fixed-format, strobe-driven transmitter: framing, bit timing and buffering now live inside the block.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: parity selection, TX FSM states and
// an even-parity helper sized for the widest legal data word.
package uart_pkg;

   localparam int unsigned MAX_DATA_W = 9;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Callers zero-extend narrower words; zero bits do not disturb the XOR.
   function automatic logic even_parity(input logic [MAX_DATA_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock word FIFO with registered occupancy; full/empty derive from
// the level register, so a same-cycle pop never re-opens a full FIFO early.
module uart_sync_fifo #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic                        pop,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] level
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       level_q, level_d;
   logic              do_push, do_pop;

   assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffered UART transmitter: word FIFO feeding a start/data/parity/stop framer
// with per-frame latched baud divisor, parity mode and stop-bit count.
module uart_tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   input  logic [DIV_W-1:0]            baud_div,
   input  logic [1:0]                  parity_mode,
   input  logic                        two_stop,
   output logic                        serial_out,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int unsigned CW = $clog2(DATA_W);

   tx_state_e             state_q, state_d;
   logic [DIV_W-1:0]      baud_cnt_q, baud_cnt_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]     shreg_q, shreg_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  two_stop_q, two_stop_d;
   logic                  stop2_q, stop2_d;
   logic                  serial_q, serial_d;
   logic                  busy_q, busy_d;

   logic                  fifo_full, fifo_empty, fifo_pop, load, tick;
   logic [DATA_W-1:0]     fifo_rd_data;
   logic [MAX_DATA_W-1:0] par_ext;
   parity_e               par_mode;

   uart_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (tx_valid),
      .wr_data (tx_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign tx_ready   = !fifo_full;
   assign serial_out = serial_q;
   assign busy       = busy_q;

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      div_d      = div_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      stop2_d    = stop2_q;
      load       = 1'b0;
      fifo_pop   = 1'b0;
      tick       = (baud_cnt_q == div_q);
      par_mode   = parity_e'(parity_mode);
      par_ext    = '0;
      par_ext[DATA_W-1:0] = fifo_rd_data;

      if (state_q != IDLE) baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_W'(1);

      case (state_q)
         IDLE:   if (!fifo_empty) load = 1'b1;
         START:  if (tick) begin
            state_d   = DATA;
            bit_cnt_d = '0;
         end
         DATA:   if (tick) begin
            if (bit_cnt_q == CW'(DATA_W-1)) begin
               state_d = par_en_q ? PARITY : STOP;
               stop2_d = 1'b0;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
               shreg_d   = shreg_q >> 1;
            end
         end
         PARITY: if (tick) begin
            state_d = STOP;
            stop2_d = 1'b0;
         end
         STOP:   if (tick) begin
            if (two_stop_q && !stop2_q) stop2_d = 1'b1;
            else if (!fifo_empty)       load    = 1'b1;
            else                        state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Frame config is captured only here, so mid-frame input changes wait.
      if (load) begin
         fifo_pop   = 1'b1;
         state_d    = START;
         baud_cnt_d = '0;
         shreg_d    = fifo_rd_data;
         div_d      = baud_div;
         par_en_d   = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
         par_bit_d  = even_parity(par_ext) ^ (par_mode == PAR_ODD);
         two_stop_d = two_stop;
      end

      // Line value follows the state being entered, keeping serial_out a flop.
      case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shreg_d[0];
         PARITY:  serial_d = par_bit_d;
         default: serial_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         div_q      <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         stop2_q    <= 1'b0;
         serial_q   <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         div_q      <= div_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         stop2_q    <= stop2_d;
         serial_q   <= serial_d;
         busy_q     <= busy_d;
      end
   end

endmodule
